// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift register command sequencer:
// shift register opcodes, sequencer states and small decode helpers.
package shift_seq_pkg;

  localparam int unsigned DATA_LEN_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT    = 4;

  // Opcodes understood by the downstream 8-bit shift register stage.
  typedef enum logic [2:0] {
    OP_CLR  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSR  = 3'b010,
    OP_LSL  = 3'b011,
    OP_ASR  = 3'b100,
    OP_SIN  = 3'b101,
    OP_ROR  = 3'b110,
    OP_ROL  = 3'b111
  } sr_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Opcodes that complete in the load cycle regardless of the shift count.
  function automatic logic op_is_single_cycle(input logic [2:0] op);
    return (op == OP_CLR) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 8-bit shift register stage.
// Accepts a request over valid/ready, issues one load cycle followed by
// N shift cycles on sr_ctrl/sr_d/sr_a, then presents sr_q as the response.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort input and the
// resp_aborted output; without it every request runs to completion.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned DATA_LEN = DATA_LEN_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [DATA_LEN-1:0] req_data,
  input  logic [CNT_W-1:0]    req_count,
  input  logic [DATA_LEN-1:0] req_serial,
  output logic [2:0]          sr_ctrl,
  output logic [DATA_LEN-1:0] sr_d,
  output logic                sr_a,
  input  logic [DATA_LEN-1:0] sr_q,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic                abort,
  output logic                resp_aborted,
`endif
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_data
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state;
  state_e              state_nxt;
  logic [2:0]          op_r;
  logic [DATA_LEN-1:0] data_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_LEN-1:0] ser_r;
  logic [2:0]          sr_ctrl_nxt;
  logic                accept;
  logic                abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort && ((state == S_LOAD) || (state == S_SHIFT));
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = (state == S_IDLE) && req_valid;

  // State register; reset parks the sequencer in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the value sr_ctrl must hold in the coming state.
  always_comb begin
    state_nxt   = state;
    sr_ctrl_nxt = OP_LOAD;
    unique case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (abort_hit || op_is_single_cycle(op_r) || (cnt_r == '0))
          state_nxt = S_DONE;
        else
          state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort_hit || (cnt_r == CNT_ONE)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // sr_ctrl is registered, so it is chosen from the state being entered.
    // LOAD is only entered from IDLE, where the opcode is still on req_op.
    unique case (state_nxt)
      S_LOAD:  sr_ctrl_nxt = (req_op == OP_CLR) ? OP_CLR : OP_LOAD;
      S_SHIFT: sr_ctrl_nxt = op_r;
      default: sr_ctrl_nxt = OP_LOAD;
    endcase
  end

  // Shift register control register; held at clear while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_ctrl <= OP_CLR;
    end else begin
      sr_ctrl <= sr_ctrl_nxt;
    end
  end

  // Request capture, shift counter and serial-bit rotator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= '0;
      data_r <= '0;
      cnt_r  <= '0;
      ser_r  <= '0;
    end else if (accept) begin
      op_r   <= req_op;
      data_r <= req_data;
      cnt_r  <= req_count;
      ser_r  <= req_serial;
    end else if (state == S_SHIFT) begin
      cnt_r <= cnt_r - CNT_ONE;
      // Rotation makes counts beyond DATA_LEN wrap the serial index.
      ser_r <= {ser_r[0], ser_r[DATA_LEN-1:1]};
    end
  end

`ifdef SHIFT_SEQ_ABORT_EN
  // Abort flag: set when a request is cut short, cleared on the response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_aborted <= 1'b0;
    end else if (abort_hit) begin
      resp_aborted <= 1'b1;
    end else if ((state == S_DONE) && resp_ready) begin
      resp_aborted <= 1'b0;
    end
  end
`endif

  // Handshake and datapath outputs derived from the current state.
  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    resp_valid = (state == S_DONE);
    resp_data  = sr_q;
    sr_d       = (state == S_LOAD) ? data_r : sr_q;
    sr_a       = ser_r[0];
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shift register
// stage wired in the loop (sr_q fed from its output).
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic [3:0] req_count;
  logic [7:0] req_serial;
  logic [2:0] sr_ctrl;
  logic [7:0] sr_d;
  logic       sr_a;
  logic [7:0] sr_out;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
`ifdef SHIFT_SEQ_ABORT_EN
  logic       abort;
  logic       resp_aborted;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.DATA_LEN(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_count  (req_count),
    .req_serial (req_serial),
    .sr_ctrl    (sr_ctrl),
    .sr_d       (sr_d),
    .sr_a       (sr_a),
    .sr_q       (sr_out),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort        (abort),
    .resp_aborted (resp_aborted),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  // Downstream 8-bit shift register stage.
  always @(posedge clk) begin
    case (sr_ctrl)
      3'b000: sr_out <= 8'h00;
      3'b001: sr_out <= sr_d;
      3'b010: sr_out <= {1'b0, sr_out[7:1]};
      3'b011: sr_out <= {sr_out[6:0], 1'b0};
      3'b100: sr_out <= {sr_out[7], sr_out[7:1]};
      3'b101: sr_out <= {sr_a, sr_out[7:1]};
      3'b110: sr_out <= {sr_out[0], sr_out[7:1]};
      default: sr_out <= {sr_out[6:0], sr_out[7]};
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns just after the accept edge E0.
  task automatic start_req(input logic [2:0] op, input logic [7:0] data,
                           input logic [3:0] cnt, input logic [7:0] ser);
    check("req_ready_before_req", {7'b0, req_ready}, 8'h01);
    req_op     = op;
    req_data   = data;
    req_count  = cnt;
    req_serial = ser;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  // Walk edges E1..E(lat): resp_valid must rise exactly at E(lat).
  task automatic wait_resp(input int lat, input logic [7:0] exp_data,
                           input logic chk_a, input int cnt, input logic [7:0] ser);
    for (int k = 1; k <= lat; k++) begin
      tick();
      check($sformatf("resp_valid_E%0d", k), {7'b0, resp_valid}, {7'b0, (k == lat)});
      if (chk_a && k <= cnt)
        check($sformatf("sr_a_shift%0d", k), {7'b0, sr_a}, {7'b0, ser[(k - 1) % 8]});
    end
    check("resp_data", resp_data, exp_data);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_valid_after_hs", {7'b0, resp_valid}, 8'h00);
    check("req_ready_after_hs", {7'b0, req_ready}, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    req_data   = 8'h00;
    req_count  = 4'h0;
    req_serial = 8'h00;
    resp_ready = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort      = 1'b0;
`endif

    // Reset held for two cycles.
    #1;
    check("rst_sr_ctrl", {5'b0, sr_ctrl}, 8'h00);
    check("rst_req_ready", {7'b0, req_ready}, 8'h00);
    check("rst_resp_valid", {7'b0, resp_valid}, 8'h00);
`ifdef SHIFT_SEQ_ABORT_EN
    check("rst_resp_aborted", {7'b0, resp_aborted}, 8'h00);
`endif
    tick();
    tick();
    check("rst_sr_out", sr_out, 8'h00);
    rst = 1'b0;
    #1;
    check("rel_req_ready", {7'b0, req_ready}, 8'h01);
    tick();
    check("rel_sr_ctrl", {5'b0, sr_ctrl}, 8'h01);

    // LSL 0x81 by 3 -> 0x08 at E4, then 5 cycles of backpressure.
    start_req(3'b011, 8'h81, 4'd3, 8'h00);
    wait_resp(4, 8'h08, 1'b0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_resp_valid", {7'b0, resp_valid}, 8'h01);
      check("bp_resp_data", resp_data, 8'h08);
      check("bp_sr_ctrl", {5'b0, sr_ctrl}, 8'h01);
      check("bp_req_ready", {7'b0, req_ready}, 8'h00);
    end
    handshake();

    // ASR 0x90 by 2 -> 0xE4 at E3.
    start_req(3'b100, 8'h90, 4'd2, 8'h00);
    wait_resp(3, 8'hE4, 1'b0, 0, 8'h00);
    handshake();

    // Serial-in 0x05, 3 shifts: sr_a 1,0,1 -> 0xA0.
    start_req(3'b101, 8'h00, 4'd3, 8'h05);
    wait_resp(4, 8'hA0, 1'b1, 3, 8'h05);
    handshake();

    // Serial-in 0x05, 10 shifts: bit index wraps after 8 -> 0x41.
    start_req(3'b101, 8'h00, 4'd10, 8'h05);
    wait_resp(11, 8'h41, 1'b1, 10, 8'h05);
    handshake();

    // ROR with count 0: load only, response at E1.
    start_req(3'b110, 8'h3C, 4'd0, 8'h00);
    wait_resp(1, 8'h3C, 1'b0, 0, 8'h00);
    handshake();

    // Clear after a prior result, with a second request held on req_valid.
    start_req(3'b000, 8'hA5, 4'd7, 8'h00);
    req_op    = 3'b001;
    req_data  = 8'h5A;
    req_count = 4'd0;
    req_valid = 1'b1;
    wait_resp(1, 8'h00, 1'b0, 0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("b2b_req_ready", {7'b0, req_ready}, 8'h00);
      check("b2b_resp_data", resp_data, 8'h00);
    end
    handshake();
    tick();
    req_valid = 1'b0;
    wait_resp(1, 8'h5A, 1'b0, 0, 8'h00);
    handshake();

    // Plain load ignores the count.
    start_req(3'b001, 8'hC3, 4'd5, 8'h00);
    wait_resp(1, 8'hC3, 1'b0, 0, 8'h00);
    handshake();

    // Maximum count: ROL 0x01 by 15 -> 0x80.
    start_req(3'b111, 8'h01, 4'd15, 8'h00);
    wait_resp(16, 8'h80, 1'b0, 0, 8'h00);
    handshake();

    // Reset pulse in the middle of LSR 0xFF by 8.
    start_req(3'b010, 8'hFF, 4'd8, 8'h00);
    tick();
    tick();
    tick();
    check("mid_sr_out", sr_out, 8'h3F);
    rst = 1'b1;
    #1;
    check("mid_rst_resp_valid", {7'b0, resp_valid}, 8'h00);
    check("mid_rst_req_ready", {7'b0, req_ready}, 8'h00);
    check("mid_rst_sr_ctrl", {5'b0, sr_ctrl}, 8'h00);
    tick();
    check("mid_rst_sr_out", sr_out, 8'h00);
    rst = 1'b0;
    #1;
    check("mid_rel_req_ready", {7'b0, req_ready}, 8'h01);
    check("mid_rel_resp_valid", {7'b0, resp_valid}, 8'h00);
    tick();

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort in IDLE has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_req_ready", {7'b0, req_ready}, 8'h01);
    check("idle_abort_flag", {7'b0, resp_aborted}, 8'h00);

    // Abort after two shifts of LSR 0xFF by 8 -> partial 0x3F.
    start_req(3'b010, 8'hFF, 4'd8, 8'h00);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_resp_valid", {7'b0, resp_valid}, 8'h01);
    check("abort_resp_data", resp_data, 8'h3F);
    check("abort_flag", {7'b0, resp_aborted}, 8'h01);
    handshake();
    check("abort_flag_cleared", {7'b0, resp_aborted}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
